// File: rtl/regfile_wport_arb.sv
// Regfile write-port arbiter: WB has priority, aux writes are queued in a FIFO with a
// starvation-forced grant. Optional macro RF_ARB_BYPASS_EN lets aux skip an empty FIFO.
module regfile_wport_arb #(
  parameter int AUX_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic [31:0] wb_rd_wdata_i,
  output logic        wb_stall_o,
  input  logic        aux_valid_i,
  input  logic [4:0]  aux_rd_addr_i,
  input  logic [31:0] aux_rd_wdata_i,
  output logic        aux_ready_o,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  output logic        aux_hazard_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);
  localparam int PW = $clog2(AUX_DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_wr_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

  rf_wr_t [AUX_DEPTH-1:0] fifo_q;
  logic   [AUX_DEPTH-1:0] vld_q;
  logic   [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic   [PW:0]          cnt_q, cnt_d;
  logic   [CW-1:0]        starve_q, starve_d;
  state_t                 state_q, state_d;

  logic   wb_req, full, empty, push, pop, bypass;
  logic   grant_wb, grant_head, stall;
  logic   we;
  logic   [4:0]  waddr;
  logic   [31:0] wdata;
  rf_wr_t head;

  assign wb_req = wb_we_i && (wb_rd_addr_i != 5'd0);
  assign full   = (cnt_q == (PW+1)'(AUX_DEPTH));
  assign empty  = (cnt_q == '0);
  assign head   = fifo_q[rd_ptr_q];

`ifdef RF_ARB_BYPASS_EN
  assign bypass = empty && !wb_req && aux_valid_i;
`else
  assign bypass = 1'b0;
`endif

  // S_IDLE implies an empty FIFO, so only WB (or a bypassed aux) can win there.
  always_comb begin
    grant_wb   = 1'b0;
    grant_head = 1'b0;
    stall      = 1'b0;
    case (state_q)
      S_WAIT: begin
        grant_wb   = wb_req;
        grant_head = !wb_req;
      end
      S_FORCE: begin
        grant_head = 1'b1;
        stall      = wb_req;
      end
      default: grant_wb = wb_req;
    endcase
  end

  assign pop  = grant_head;
  assign push = aux_valid_i && !full && !bypass;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (grant_head) begin
      we    = (head.addr != 5'd0);
      waddr = head.addr;
      wdata = head.data;
    end else if (grant_wb) begin
      we    = 1'b1;
      waddr = wb_rd_addr_i;
      wdata = wb_rd_wdata_i;
    end else if (bypass) begin
      we    = (aux_rd_addr_i != 5'd0);
      waddr = aux_rd_addr_i;
      wdata = aux_rd_wdata_i;
    end
  end

  // Starvation only accrues while WB beats a waiting head.
  always_comb begin
    cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    starve_d = starve_q;
    if (pop)
      starve_d = '0;
    else if (state_q == S_WAIT && grant_wb)
      starve_d = starve_q + CW'(1);
    if (cnt_d == '0)
      state_d = S_IDLE;
    else if (state_q == S_WAIT && !pop && starve_d == CW'(STARVE_MAX))
      state_d = S_FORCE;
    else
      state_d = S_WAIT;
  end

  logic [AUX_DEPTH-1:0] hit;
  for (genvar i = 0; i < AUX_DEPTH; i++) begin : g_haz
    assign hit[i] = vld_q[i] &&
                    ((id_rs1_addr_i != 5'd0 && fifo_q[i].addr == id_rs1_addr_i) ||
                     (id_rs2_addr_i != 5'd0 && fifo_q[i].addr == id_rs2_addr_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q   <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      state_q  <= S_IDLE;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {aux_rd_addr_i, aux_rd_wdata_i};
        vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      state_q  <= state_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign rf_we_o      = rst_ni && we;
  assign rf_waddr_o   = rst_ni ? waddr : '0;
  assign rf_wdata_o   = rst_ni ? wdata : '0;
  assign wb_stall_o   = rst_ni && stall;
  assign aux_ready_o  = rst_ni && !full;
  assign aux_hazard_o = rst_ni && (|hit);
endmodule

// File: tb/tb_regfile_wport_arb.sv
// Scoreboard bench for regfile_wport_arb: expected commits queued at drive time, popped on rf_we_o.
module tb_regfile_wport_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we, wb_stall, aux_v, aux_ready, hazard, rf_we;
  logic [4:0]  wb_a, aux_a, rs1, rs2, rf_waddr;
  logic [31:0] wb_d, aux_d, rf_wdata;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

`ifdef RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_wport_arb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_we_i(wb_we), .wb_rd_addr_i(wb_a), .wb_rd_wdata_i(wb_d), .wb_stall_o(wb_stall),
    .aux_valid_i(aux_v), .aux_rd_addr_i(aux_a), .aux_rd_wdata_i(aux_d), .aux_ready_o(aux_ready),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .aux_hazard_o(hazard),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expw(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drv(input logic we, input logic [4:0] a, input logic [31:0] d,
                     input logic av, input logic [4:0] aa, input logic [31:0] ad);
    @(posedge clk); #1;
    wb_we = we; wb_a = a; wb_d = d;
    aux_v = av; aux_a = aa; aux_d = ad;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) chk("sb_unexpected_we", {27'd0, rf_waddr, rf_wdata}, 64'd0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_commit", {27'd0, rf_waddr, rf_wdata}, {27'd0, e.a, e.d});
      end
    end
  end

  initial begin
    wb_we = 1'b1; wb_a = 5'd5; wb_d = 32'hA5;
    aux_v = 1'b1; aux_a = 5'd1; aux_d = 32'h1;
    rs1 = 5'd0; rs2 = 5'd0;
    // reset holds all outputs low even with requests present
    smp();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_aux_ready", aux_ready, 0);
    chk("rst_stall", wb_stall, 0);
    drv(1, 5, 32'hA5, 0, 0, 0); rst_n = 1'b1; expw(5, 32'hA5);
    smp();
    chk("wb_first_we", rf_we, 1);
    chk("wb_first_addr", rf_waddr, 5);

    // aux write on an idle port
    drv(0, 0, 0, 1, 3, 32'h33); rs1 = 5'd3; expw(3, 32'h33);
    smp();
    chk("idle_aux_ready", aux_ready, 1);
    chk("idle_c0_we", rf_we, BYP);
    chk("idle_c0_haz", hazard, 0);
    drv(0, 0, 0, 0, 0, 0);
    smp();
    chk("idle_c1_we", rf_we, !BYP);
    chk("idle_c1_haz", hazard, !BYP);
    drv(0, 0, 0, 0, 0, 0);
    smp();
    chk("idle_c2_haz", hazard, 0);
    rs1 = 5'd0;

    // starvation: 4 WB wins then a forced aux grant
    drv(1, 10, 100, 1, 7, 32'h77); expw(10, 100);
    smp();
    chk("st_ready", aux_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      drv(1, 10, 100 + k, 0, 0, 0); expw(10, 100 + k);
      smp();
      chk($sformatf("st_wb_addr%0d", k), rf_waddr, 10);
      chk($sformatf("st_nostall%0d", k), wb_stall, 0);
    end
    drv(1, 10, 105, 0, 0, 0); expw(7, 32'h77); expw(10, 105);
    smp();
    chk("st_force_addr", rf_waddr, 7);
    chk("st_force_stall", wb_stall, 1);
    drv(1, 10, 105, 0, 0, 0);
    smp();
    chk("st_held_addr", rf_waddr, 10);
    chk("st_held_data", rf_wdata, 105);
    chk("st_held_nostall", wb_stall, 0);

    // full FIFO, non-pop-aware ready, pop+push in one cycle
    drv(1, 10, 200, 1, 20, 32'h20); expw(10, 200);
    smp(); chk("f_ready0", aux_ready, 1);
    drv(1, 10, 201, 1, 21, 32'h21); expw(10, 201);
    smp(); chk("f_ready1", aux_ready, 1);
    drv(1, 10, 202, 1, 22, 32'h22); rs1 = 5'd20; rs2 = 5'd21; expw(10, 202);
    smp(); chk("f_full", aux_ready, 0); chk("f_haz", hazard, 1);
    drv(1, 10, 203, 1, 22, 32'h22); expw(10, 203);
    smp(); chk("f_full_hold", aux_ready, 0);
    drv(1, 10, 204, 1, 22, 32'h22); expw(10, 204);
    smp();
    drv(1, 10, 205, 1, 22, 32'h22); expw(20, 32'h20); expw(10, 205);
    smp();
    chk("f_force_addr", rf_waddr, 20);
    chk("f_force_stall", wb_stall, 1);
    chk("f_ready_on_pop", aux_ready, 0);
    drv(1, 10, 205, 1, 22, 32'h22);
    smp(); chk("f_ready_after_pop", aux_ready, 1);
    drv(0, 0, 0, 1, 23, 32'h23); expw(21, 32'h21);
    smp(); chk("f_full_again", aux_ready, 0);
    drv(0, 0, 0, 1, 23, 32'h23); rs1 = 5'd22; rs2 = 5'd0; expw(22, 32'h22);
    smp(); chk("f_pp_ready", aux_ready, 1); chk("f_pp_haz", hazard, 1);
    drv(0, 0, 0, 0, 0, 0); rs2 = 5'd23; expw(23, 32'h23);
    smp(); chk("f_haz_last", hazard, 1);
    drv(0, 0, 0, 0, 0, 0);
    smp(); chk("f_drained_haz", hazard, 0);
    rs1 = 5'd0; rs2 = 5'd0;

    // x0 handling on both sides
    drv(1, 10, 300, 1, 9, 32'h99); expw(10, 300);
    smp(); chk("x0_ready", aux_ready, 1);
    drv(1, 0, 32'hDEAD, 0, 0, 0); expw(9, 32'h99);
    smp(); chk("x0_wb_aux_addr", rf_waddr, 9); chk("x0_wb_nostall", wb_stall, 0);
    drv(1, 10, 301, 1, 0, 32'h55); expw(10, 301);
    smp(); chk("x0_aux_ready", aux_ready, 1);
    drv(0, 0, 0, 0, 0, 0);
    smp(); chk("x0_aux_pop_we", rf_we, 0);
    drv(0, 0, 0, 0, 0, 0);
    smp(); chk("x0_after_we", rf_we, 0);

    // reset mid-operation drops pending aux writes
    drv(1, 10, 400, 1, 12, 32'h12); expw(10, 400);
    smp();
    drv(1, 10, 401, 1, 13, 32'h13); expw(10, 401);
    smp(); chk("mr_ready", aux_ready, 1);
    drv(0, 0, 0, 0, 0, 0); rst_n = 1'b0; rs1 = 5'd12; rs2 = 5'd13;
    smp(); chk("mr_in_haz", hazard, 0); chk("mr_in_we", rf_we, 0);
    drv(0, 0, 0, 0, 0, 0); rst_n = 1'b1;
    smp(); chk("mr_out_haz", hazard, 0); chk("mr_out_we", rf_we, 0); chk("mr_out_ready", aux_ready, 1);
    drv(0, 0, 0, 0, 0, 0);
    smp(); chk("mr_no_write", rf_we, 0);
    drv(0, 0, 0, 0, 0, 0);
    smp(); chk("mr_no_write2", rf_we, 0);

    chk("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
